// File: rtl/apb_cfg_pkg.sv
// Shared types for the matrix-multiplier configuration APB requester.
package apb_cfg_pkg;

    // Widths the command/response structs are built from; the master's
    // ADDR_W/DATA_W parameters default to these and must match them.
    localparam int unsigned CFG_ADDR_W = 16;
    localparam int unsigned CFG_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [CFG_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_cfg_master.sv
// APB requester for the accelerator configuration bus: one APB transfer per
// accepted command, with an optional wait-state timeout that aborts the
// transfer and reports it on the response channel.
module apb_cfg_master
    import apb_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W  = CFG_ADDR_W,
    parameter int unsigned DATA_W  = CFG_DATA_W,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // Command channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // Response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB requester
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // Counter wide enough to hold TIMEOUT; a 1-bit stub when disabled.
    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    apb_state_e      state_q, state_d;
    apb_cmd_t        cmd_q, cmd_d;
    apb_rsp_t        rsp_q, rsp_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_hit;

    // Last permitted ACCESS cycle with the slave still stalling.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CntLast);

    // Next-state logic: command capture, APB phase sequencing, response capture.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        rsp_d      = rsp_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cmd_d.write = req_write;
                    cmd_d.addr  = req_addr;
                    cmd_d.wdata = req_wdata;
                    wait_cnt_d  = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    // A completing slave beats the timeout in the same cycle.
                    rsp_d.rdata   = cmd_q.write ? '0 : prdata;
                    rsp_d.err     = pslverr;
                    rsp_d.timeout = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight transfer without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            rsp_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            rsp_q      <= rsp_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs decode from the state register or come straight from registers.
    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign psel        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable     = (state_q == ACCESS);
    assign pwrite      = cmd_q.write;
    assign paddr       = cmd_q.addr;
    assign pwdata      = cmd_q.wdata;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Self-checking bench for apb_cfg_master: directed transfers plus random
// commands against a transaction-level expectation of latency and response.
module tb_apb_cfg_master;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        psel, penable, pwrite;
    logic [15:0] paddr, pwdata, prdata;
    logic        pready, pslverr;

    int vectors = 0;
    int errors  = 0;

    apb_cfg_master #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One command, starting at a falling edge with the DUT idle. The slave
    // raises pready after 'w' stalled ACCESS cycles; w >= TMO never completes.
    // Ends at the falling edge after the response handshake (DUT idle again).
    task automatic run_cmd(input logic wr, input logic [15:0] a, input logic [15:0] d,
                           input int w, input logic serr, input logic [15:0] sdata,
                           input int stall);
        int          exp_acc;
        logic        exp_to;
        logic        exp_err;
        logic [15:0] exp_rdata;
        exp_to    = (w >= int'(TMO));
        exp_acc   = exp_to ? int'(TMO) : w + 1;
        exp_err   = exp_to ? 1'b1 : serr;
        exp_rdata = (exp_to || wr) ? 16'h0 : sdata;

        check("idle_req_ready", req_ready, 1);
        check("idle_psel", psel, 0);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;

        @(negedge clk);  // SETUP
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
        check("setup_req_ready", req_ready, 0);
        check("setup_paddr", paddr, a);
        check("setup_pwrite", pwrite, wr);
        check("setup_pwdata", pwdata, d);
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = 16'($urandom);

        for (int k = 0; k < exp_acc; k++) begin
            @(negedge clk);  // ACCESS cycle k
            check("access_psel", psel, 1);
            check("access_penable", penable, 1);
            check("access_rsp_valid", rsp_valid, 0);
            check("access_paddr", paddr, a);
            check("access_pwrite", pwrite, wr);
            check("access_pwdata", pwdata, d);
            pready  = (k == w);
            pslverr = (k == w) ? serr : 1'($urandom);
            prdata  = (k == w) ? sdata : 16'($urandom);
        end

        @(negedge clk);  // RESP
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = 16'($urandom);
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clk);
            check("resp_valid", rsp_valid, 1);
            check("resp_psel", psel, 0);
            check("resp_penable", penable, 0);
            check("resp_req_ready", req_ready, 0);
            check("resp_rdata", rsp_rdata, exp_rdata);
            check("resp_err", rsp_err, exp_err);
            check("resp_timeout", rsp_timeout, exp_to);
            check("resp_paddr_held", paddr, a);
            // Offer a competing request while the response is stalled.
            req_valid = (s < stall) ? 1'($urandom) | (stall >= 10) : 1'b0;
            rsp_ready = (s == stall);
        end

        @(negedge clk);  // back in IDLE
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", req_ready, 1);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_cmd(1'b1, 16'h0000, 16'h1000, 0, 1'b0, 16'h0000, 0);  // zero-wait write
        run_cmd(1'b0, 16'h000C, 16'h0000, 3, 1'b0, 16'h0008, 0);  // read, 3 waits
        run_cmd(1'b1, 16'h0010, 16'hBEEF, 1, 1'b1, 16'h0000, 0);  // slave error
        run_cmd(1'b0, 16'h0004, 16'h0000, 99, 1'b0, 16'h1234, 0); // timeout
        run_cmd(1'b0, 16'h0006, 16'h0000, 3, 1'b0, 16'h4321, 0);  // pready on last cycle
        run_cmd(1'b0, 16'h0020, 16'h0000, 0, 1'b0, 16'hA5A5, 10); // stalled response

        // Reset in the middle of ACCESS
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0ABC;
        req_wdata = 16'h5555;
        @(negedge clk);  // SETUP
        req_valid = 1'b0;
        @(negedge clk);  // ACCESS
        check("pre_rst_penable", penable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_psel", psel, 0);
        check("mid_rst_penable", penable, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_paddr", paddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rsp_valid", rsp_valid, 0);
        run_cmd(1'b0, 16'h0002, 16'h0000, 2, 1'b0, 16'h00FF, 1);

        // Random commands
        for (int n = 0; n < 40; n++) begin
            run_cmd(1'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 6)), 1'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
